// File: rtl/goal_referee.sv
// Goal referee: watches the ball position once per frame, awards goals after a
// short confirmation run, keeps the score, enforces a post-goal cooldown and ends the match.
module goal_referee #(
    parameter int RIGHT_GOAL_X   = 600,
    parameter int LEFT_GOAL_X    = 8,
    parameter int GOAL_Y_TOP     = 180,
    parameter int GOAL_Y_BOTTOM  = 300,
    parameter int CONFIRM_FRAMES = 2,
    parameter int HOLD_FRAMES    = 60,
    parameter int WIN_SCORE      = 5
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] topLeftX,
    input  logic [10:0] topLeftY,
    input  logic        newGame,
    output logic [1:0]  goalWasScored,
    output logic [3:0]  teamScore,
    output logic [3:0]  oppScore,
    output logic        gameOver,
    output logic        winner,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(CONFIRM_FRAMES + 1);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic signed [10:0] RX  = 11'(RIGHT_GOAL_X);
    localparam logic signed [10:0] LX  = 11'(LEFT_GOAL_X);
    localparam logic signed [10:0] GYT = 11'(GOAL_Y_TOP);
    localparam logic signed [10:0] GYB = 11'(GOAL_Y_BOTTOM);

    typedef enum logic [1:0] {S_PLAY, S_PULSE, S_HOLD, S_GAME_OVER} state_t;

    // Region codes double as the goalWasScored code for that side.
    localparam logic [1:0] REG_NONE = 2'b00;
    localparam logic [1:0] REG_TEAM = 2'b01;
    localparam logic [1:0] REG_OPP  = 2'b10;

    state_t          state_q, state_d;
    logic [1:0]      goal_q, goal_d;
    logic [3:0]      team_q, team_d;
    logic [3:0]      opp_q, opp_d;
    logic            winner_q, winner_d;
    logic [1:0]      side_q, side_d;
    logic [1:0]      prev_q, prev_d;
    logic [CW-1:0]   confirm_q, confirm_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic signed [10:0] x_s, y_s;
    logic               y_in;
    logic [1:0]         region;

    assign x_s  = $signed(topLeftX);
    assign y_s  = $signed(topLeftY);
    assign y_in = (y_s >= GYT) && (y_s <= GYB);

    always_comb begin
        region = REG_NONE;
        if (y_in && (x_s >= RX)) begin
            region = REG_TEAM;
        end else if (y_in && (x_s <= LX)) begin
            region = REG_OPP;
        end
    end

    always_comb begin
        state_d   = state_q;
        goal_d    = 2'b00;
        team_d    = team_q;
        opp_d     = opp_q;
        winner_d  = winner_q;
        side_d    = side_q;
        prev_d    = prev_q;
        confirm_d = confirm_q;
        hold_d    = hold_q;

        if (newGame) begin
            state_d   = S_PLAY;
            team_d    = 4'd0;
            opp_d     = 4'd0;
            winner_d  = 1'b0;
            side_d    = REG_NONE;
            prev_d    = REG_NONE;
            confirm_d = '0;
            hold_d    = '0;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (startOfFrame) begin
                        prev_d = region;
                        if ((region != REG_NONE) && (region == prev_q)) begin
                            confirm_d = confirm_q + 1'b1;
                        end else if (region != REG_NONE) begin
                            confirm_d = CW'(1);
                        end else begin
                            confirm_d = '0;
                        end
                        if (confirm_d == CW'(CONFIRM_FRAMES)) begin
                            state_d = S_PULSE;
                            side_d  = region;
                        end
                    end
                end
                S_PULSE: begin
                    goal_d  = side_q;
                    state_d = S_HOLD;
                    hold_d  = '0;
                    if (side_q == REG_TEAM) begin
                        team_d = team_q + 4'd1;
                        if (team_d == 4'(WIN_SCORE)) begin
                            state_d  = S_GAME_OVER;
                            winner_d = 1'b0;
                        end
                    end else begin
                        opp_d = opp_q + 4'd1;
                        if (opp_d == 4'(WIN_SCORE)) begin
                            state_d  = S_GAME_OVER;
                            winner_d = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (startOfFrame) begin
                        hold_d = hold_q + 1'b1;
                        // Cooldown over: detection restarts from a clean history.
                        if (hold_d == HW'(HOLD_FRAMES)) begin
                            state_d   = S_PLAY;
                            hold_d    = '0;
                            confirm_d = '0;
                            prev_d    = REG_NONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_PLAY;
            goal_q    <= 2'b00;
            team_q    <= 4'd0;
            opp_q     <= 4'd0;
            winner_q  <= 1'b0;
            side_q    <= REG_NONE;
            prev_q    <= REG_NONE;
            confirm_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            goal_q    <= goal_d;
            team_q    <= team_d;
            opp_q     <= opp_d;
            winner_q  <= winner_d;
            side_q    <= side_d;
            prev_q    <= prev_d;
            confirm_q <= confirm_d;
            hold_q    <= hold_d;
        end
    end

    assign goalWasScored = goal_q;
    assign teamScore     = team_q;
    assign oppScore      = opp_q;
    assign gameOver      = (state_q == S_GAME_OVER);
    assign winner        = winner_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_goal_referee.sv
// Bench for goal_referee: frame-level reference model feeding an expected-goal
// queue, drained by a monitor whenever the referee pulses goalWasScored.
module tb_goal_referee;

    localparam int W = 42;  // {cycle[31:0], opp[3:0], team[3:0], code[1:0]}

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        newGame;
    logic [1:0]  goalWasScored;
    logic [3:0]  teamScore;
    logic [3:0]  oppScore;
    logic        gameOver;
    logic        winner;
    logic [1:0]  dbg_state;

    goal_referee dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .topLeftX      (topLeftX),
        .topLeftY      (topLeftY),
        .newGame       (newGame),
        .goalWasScored (goalWasScored),
        .teamScore     (teamScore),
        .oppScore      (oppScore),
        .gameOver      (gameOver),
        .winner        (winner),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model, one step per frame
    int m_team, m_opp, m_over, m_winner, m_prev, m_run, m_hold;

    function automatic int region_of(input int x, input int y);
        if (y >= 180 && y <= 300) begin
            if (x >= 600) return 1;
            if (x <= 8) return 2;
        end
        return 0;
    endfunction

    task automatic model_new_game();
        m_team = 0; m_opp = 0; m_over = 0; m_winner = 0;
        m_prev = 0; m_run = 0; m_hold = 0;
    endtask

    task automatic model_frame(input int x, input int y, output bit goal);
        int r;
        goal = 0;
        if (m_over != 0) return;
        if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) begin
                m_prev = 0;
                m_run  = 0;
            end
            return;
        end
        r = region_of(x, y);
        if (r != 0 && r == m_prev) m_run++;
        else m_run = (r != 0) ? 1 : 0;
        m_prev = r;
        if (m_run == 2) begin
            goal = 1;
            if (r == 1) m_team++;
            else m_opp++;
            if (m_team == 5 || m_opp == 5) begin
                m_over   = 1;
                m_winner = (m_opp == 5) ? 1 : 0;
            end else begin
                m_hold = 60;
            end
            exp_q.push_back({32'(cyc + 2), 4'(m_opp), 4'(m_team), 2'(r)});
        end
    endtask

    // monitor: every nonzero goal code must match the head of the queue
    logic [W-1:0] mon_e;
    always @(negedge clk) begin
        if (resetN && goalWasScored != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("spurious_goal", goalWasScored, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("goal_code", goalWasScored, mon_e[1:0]);
                check("goal_team_score", teamScore, mon_e[5:2]);
                check("goal_opp_score", oppScore, mon_e[9:6]);
                check("goal_cycle", cyc, int'(mon_e[41:10]));
            end
        end
    end

    // driver tasks
    task automatic check_state(input string tag);
        check({tag, "_team"}, teamScore, m_team);
        check({tag, "_opp"}, oppScore, m_opp);
        check({tag, "_over"}, gameOver, m_over);
        if (m_over != 0) check({tag, "_winner"}, winner, m_winner);
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        newGame = 1'b1;
        model_new_game();
        @(negedge clk);
        newGame = 1'b0;
    endtask

    // ng_mode: 0 none, 1 newGame on the clk after sampling, 2 newGame after the frame
    task automatic frame(input int x, input int y, input int ng_mode);
        bit goal;
        @(negedge clk);
        startOfFrame = 1'b1;
        topLeftX = 11'(x);
        topLeftY = 11'(y);
        model_frame(x, y, goal);
        @(negedge clk);
        startOfFrame = 1'b0;
        if (ng_mode == 1) begin
            newGame = 1'b1;
            if (goal) void'(exp_q.pop_back());
            model_new_game();
        end
        @(negedge clk);
        newGame = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check_state("frame");
        if (ng_mode == 2) pulse_new_game();
    endtask

    task automatic frames(input int n, input int x, input int y);
        for (int i = 0; i < n; i++) frame(x, y, 0);
    endtask

    function automatic int pick_x(input int r);
        case (r)
            0: return $urandom_range(600, 640);
            1: return int'($urandom_range(0, 28)) - 20;
            2: return $urandom_range(590, 610);
            3: return $urandom_range(0, 16);
            default: return $urandom_range(0, 1023) - 512;
        endcase
    endfunction

    function automatic int pick_y(input int r);
        if (r <= 1) return $urandom_range(180, 300);
        if (r <= 3) return $urandom_range(170, 310);
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    initial begin
        int x, y, r, reps, ng;
        resetN = 1'b0;
        startOfFrame = 1'b0;
        topLeftX = '0;
        topLeftY = '0;
        newGame = 1'b0;
        model_new_game();
        repeat (3) @(negedge clk);
        check("reset_goal", goalWasScored, 0);
        check_state("reset");
        check("reset_winner", winner, 0);
        resetN = 1'b1;

        // team goal, then cooldown
        frames(2, 610, 200);
        frames(60, 300, 250);
        // single frame in left goal is not enough
        frame(5, 250, 0);
        frame(300, 250, 0);
        // opponent goal, held there through the cooldown and beyond
        frames(2, 5, 250);
        frames(63, 5, 250);
        frames(60, 300, 250);
        // right of goal line but above the mouth
        frames(10, 610, 100);
        // boundary corners
        frames(2, 600, 180);
        frames(60, 599, 300);
        frames(2, 8, 300);
        frames(60, 9, 200);

        // five team goals ends the match
        pulse_new_game();
        for (int g = 0; g < 5; g++) begin
            frames(2, 610, 200);
            if (g < 4) frames(60, 300, 250);
        end
        check("over_flag", gameOver, 1);
        check("over_winner", winner, 0);
        check("over_team", teamScore, 5);
        frames(10, 610, 200);
        pulse_new_game();
        @(negedge clk);
        check("ng_goal", goalWasScored, 0);
        check_state("after_ng");
        check("ng_winner", winner, 0);

        // newGame on the pulse clk cancels the goal
        frame(610, 200, 0);
        frame(610, 200, 1);
        repeat (3) @(negedge clk);
        check("cancel_team", teamScore, 0);

        // async reset during cooldown
        frames(2, 610, 200);
        frames(5, 300, 250);
        check("pre_reset_team", teamScore, 1);
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        model_new_game();
        check("midhold_reset_goal", goalWasScored, 0);
        check_state("midhold_reset");
        @(negedge clk);
        resetN = 1'b1;

        // randomized play
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 4);
            x = pick_x(r);
            y = pick_y(r);
            reps = $urandom_range(1, 3);
            for (int k = 0; k < reps; k++) begin
                ng = $urandom_range(0, 99);
                if (ng < 3) frame(x, y, 1);
                else if (ng < 5 || (m_over != 0 && ng < 30)) frame(x, y, 2);
                else frame(x, y, 0);
            end
        end

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
